alu_op_ctrl: RTL and testbench
==============================

# alu_op_ctrl

Sequencing controller for the 16-bit ALU: accepts one operation request at a time, reads both operands from the register file, drives the ALU, writes the result back and latches the ALU flags into a processor-status register. It sits between instruction decode (requester) and the ALU/register-file datapath, and serialises every ALU access through a fixed four-state FSM.

## Interface
Parameters:
- `DW`, 16, datapath width
- `AW`, 4, register-file address width (16 registers)
- `FW`, 5, flag width

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept; high only in IDLE
- `req_op`  in  5  ALU opcode: ADD=0, SUB=1, CMP=2, AND=3, OR=4, XOR=5, NOT=6, LSH=7, RSH=8, ARSH=9
- `req_src`  in  AW  Rsrc register index
- `req_dst`  in  AW  Rdest register index, also the writeback target
- `req_imm_sel`  in  1  use immediate instead of Rsrc (only with the macro)
- `req_imm`  in  DW  immediate operand
- `rf_raddr_a`  out  AW  read port A address (Rsrc)
- `rf_raddr_b`  out  AW  read port B address (Rdest)
- `rf_rdata_a`  in  DW  read data A, valid one cycle after address
- `rf_rdata_b`  in  DW  read data B, valid one cycle after address
- `rf_we`  out  1  writeback strobe
- `rf_waddr`  out  AW  writeback address
- `rf_wdata`  out  DW  writeback data
- `alu_rsrc`  out  DW  ALU Rsrc operand
- `alu_rdest`  out  DW  ALU Rdest operand
- `alu_opcode`  out  5  ALU opcode
- `alu_out`  in  DW  ALU result (combinational)
- `alu_flags`  in  FW  ALU flags (combinational)
- `psr`  out  FW  latched status flags
- `done`  out  1  one-cycle pulse, operation retired
- `err`  out  1  one-cycle pulse, illegal opcode retired

## Operation
- FSM states: IDLE → READ → EXEC → WB → IDLE; no other transitions except reset.
- IDLE: `req_ready`=1. On `req_valid & req_ready`, latch op/src/dst/imm_sel/imm, drive `rf_raddr_a`=req_src, `rf_raddr_b`=req_dst, go to READ.
- READ: capture `rf_rdata_a`/`rf_rdata_b` into operand registers; go to EXEC.
- EXEC: drive `alu_rsrc`, `alu_rdest`, `alu_opcode` from registers; capture `alu_out` and `alu_flags` at the clock edge; go to WB.
- WB: `rf_we`=1, `rf_waddr`=latched dst, `rf_wdata`=captured result, except CMP (no write) and illegal ops. `psr` ← captured flags for all legal ops including CMP. `done`=1. Go to IDLE.
- Illegal opcode (10–31): full sequence runs; in WB `rf_we`=0, `psr` unchanged, `done`=1, `err`=1.
- src==dst is legal; both read ports carry the same register.
- No arithmetic in this block; results and flags pass through unmodified, DW bits wide.
- ALU outputs are ignored outside EXEC; ALU drive outputs hold their last value in other states.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `rf_we`=0, `done`=0, `err`=0, `psr`=0, all address/data/ALU outputs 0.
- Accept at edge N; `done` high during cycle N+3; `req_ready` high again at N+4. Throughput: one op per 4 cycles.
- Writeback lands in the register file at the end of the WB cycle, so the next request reads the updated value without forwarding.
- `req_valid` while busy is ignored, with no queuing; the requester holds it until `req_ready`.
- Reset in any state: at the next edge return to IDLE with reset values; an in-flight op gets no write, no `psr` update and no `done`.

## Configuration
- `ALU_CTRL_IMM_EN` defined: when `req_imm_sel`=1 at accept, the latched `req_imm` replaces Rsrc as the ALU Rsrc operand (`rf_rdata_a` discarded); the `psr`/writeback rules are unchanged.
- Not defined: `req_imm_sel` and `req_imm` are ignored (ports remain), and Rsrc always comes from the register file.

## Test plan
- R1=1, R2=1, ADD src=R1 dst=R2 → `done` at accept+3, `rf_we`=1, `rf_waddr`=2, `rf_wdata`=0x0002.
- R3=0xFFFF, R4=0xFFFF, AND src=R3 dst=R4 → `rf_wdata`=0xFFFF; `psr` equals ALU flags sampled in EXEC.
- CMP R5=7 vs R6=7 → `rf_we` stays 0, `psr` updated (Z set), `done`=1.
- Opcode 5'b11111 → `err`=1 and `done`=1 in WB, `rf_we`=0, `psr` unchanged from the previous op.
- Reset asserted during EXEC of SUB → next cycle IDLE, `req_ready`=1, `psr`=0, no `rf_we`/`done` pulse.
- With `ALU_CTRL_IMM_EN`: ADD imm_sel=1 imm=0x0010 dst=R7 (R7=0x0005) → `rf_wdata`=0x0015. Without the macro, the same stimulus with R0=0 as src → 0x0005.

Source files
------------

// File: rtl/alu_op_ctrl_if.sv
// Request channel between instruction decode (master) and the ALU sequencing
// controller (slave): valid/ready handshake plus the operation fields.
interface alu_op_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_op;
  logic [AW-1:0] req_src;
  logic [AW-1:0] req_dst;
  logic          req_imm_sel;
  logic [DW-1:0] req_imm;

  modport master (
    output req_valid, req_op, req_src, req_dst, req_imm_sel, req_imm,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_src, req_dst, req_imm_sel, req_imm,
    output req_ready
  );
endinterface

// File: rtl/alu_op_ctrl.sv
// ALU sequencing controller: IDLE -> READ -> EXEC -> WB, one op per four cycles.
// Optional immediate-operand path enabled by defining ALU_CTRL_IMM_EN.
module alu_op_ctrl #(
  parameter int DW = 16,
  parameter int AW = 4,
  parameter int FW = 5
) (
  input  logic          clk,
  input  logic          reset,
  alu_op_ctrl_if.slave  req,
  output logic [AW-1:0] rf_raddr_a,
  output logic [AW-1:0] rf_raddr_b,
  input  logic [DW-1:0] rf_rdata_a,
  input  logic [DW-1:0] rf_rdata_b,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [DW-1:0] alu_rsrc,
  output logic [DW-1:0] alu_rdest,
  output logic [4:0]    alu_opcode,
  input  logic [DW-1:0] alu_out,
  input  logic [FW-1:0] alu_flags,
  output logic [FW-1:0] psr,
  output logic          done,
  output logic          err
);

  localparam logic [4:0] OP_CMP  = 5'd2;
  localparam logic [4:0] OP_LAST = 5'd9;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t        state, state_nxt;
  logic          ready;
  logic          accept;
  logic [4:0]    op_p0;
  logic [DW-1:0] rsrc_sel;
  logic [FW-1:0] flags_p2;

  function automatic logic op_legal(input logic [4:0] op);
    return op <= OP_LAST;
  endfunction

  assign req.req_ready = ready;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    accept    = 1'b0;
    rf_we     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (req.req_valid) begin
          accept    = 1'b1;
          state_nxt = S_READ;
        end
      end
      S_READ: state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_WB;
      S_WB: begin
        done      = 1'b1;
        err       = !op_legal(alu_opcode);
        rf_we     = op_legal(alu_opcode) && (alu_opcode != OP_CMP);
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // p0: request fields latched at accept
  always_ff @(posedge clk) begin
    if (accept) op_p0 <= req.req_op;
  end

`ifdef ALU_CTRL_IMM_EN
  logic          imm_sel_p0;
  logic [DW-1:0] imm_p0;

  always_ff @(posedge clk) begin
    if (accept) begin
      imm_sel_p0 <= req.req_imm_sel;
      imm_p0     <= req.req_imm;
    end
  end

  assign rsrc_sel = imm_sel_p0 ? imm_p0 : rf_rdata_a;
`else
  logic unused_imm;
  assign unused_imm = ^{req.req_imm_sel, req.req_imm};
  assign rsrc_sel   = rf_rdata_a;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_raddr_a <= '0;
      rf_raddr_b <= '0;
      alu_rsrc   <= '0;
      alu_rdest  <= '0;
      alu_opcode <= '0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      psr        <= '0;
    end else begin
      if (accept) begin
        rf_raddr_a <= req.req_src;
        rf_raddr_b <= req.req_dst;
      end
      // p1: operands captured at end of READ; they drive the ALU until the next op
      if (state == S_READ) begin
        alu_rsrc   <= rsrc_sel;
        alu_rdest  <= rf_rdata_b;
        alu_opcode <= op_p0;
      end
      // p2: ALU result and flags captured at end of EXEC
      if (state == S_EXEC) begin
        rf_wdata <= alu_out;
        flags_p2 <= alu_flags;
        rf_waddr <= rf_raddr_b;
      end
      if (state == S_WB && op_legal(alu_opcode)) psr <= flags_p2;
    end
  end

endmodule

// File: tb/tb_alu_op_ctrl.sv
// Self-checking bench for alu_op_ctrl: behavioural register file and ALU around
// the DUT, with a transaction-level scoreboard of register contents and psr.
module tb_alu_op_ctrl;

`ifdef ALU_CTRL_IMM_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we;
  logic [15:0] alu_rsrc, alu_rdest, alu_out;
  logic [4:0]  alu_opcode, alu_flags, psr;
  logic        done, err;

  logic [15:0] rf  [16];
  logic [15:0] mrf [16];
  logic [4:0]  mpsr;
  logic        pre_we;
  logic [3:0]  pre_addr;
  logic [15:0] pre_data;

  int checks = 0;
  int passes = 0;

  alu_op_ctrl_if #(.DW(16), .AW(4)) rq ();

  alu_op_ctrl #(.DW(16), .AW(4), .FW(5)) dut (
    .clk(clk), .reset(reset), .req(rq.slave),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_rsrc(alu_rsrc), .alu_rdest(alu_rdest), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .psr(psr), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // result/flags of "Rdest op Rsrc"; flags = {C, Z, N, unsigned lt, signed lt}
  function automatic logic [20:0] alu_model(input logic [4:0] op, input logic [15:0] s,
                                            input logic [15:0] d);
    logic [16:0] w;
    logic [15:0] r;
    w = 17'd0;
    r = 16'd0;
    case (op)
      5'd0:       begin w = {1'b0, d} + {1'b0, s}; r = w[15:0]; end
      5'd1, 5'd2: begin w = {1'b0, d} - {1'b0, s}; r = w[15:0]; end
      5'd3: r = d & s;
      5'd4: r = d | s;
      5'd5: r = d ^ s;
      5'd6: r = ~s;
      5'd7: r = d << s[3:0];
      5'd8: r = d >> s[3:0];
      5'd9: r = $signed(d) >>> s[3:0];
      default: r = 16'd0;
    endcase
    return {w[16], (r == 16'd0), r[15], (d < s), ($signed(d) < $signed(s)), r};
  endfunction

  logic [20:0] alu_res;
  assign alu_res    = alu_model(alu_opcode, alu_rsrc, alu_rdest);
  assign alu_out    = alu_res[15:0];
  assign alu_flags  = alu_res[20:16];
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  always @(posedge clk) begin
    if (rf_we)       rf[rf_waddr] <= rf_wdata;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end

  task automatic load_reg(input logic [3:0] a, input logic [15:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = v; mrf[a] = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // One transaction; entered and left at a falling edge while the DUT is idle.
  task automatic do_op(input logic [4:0] op, input logic [3:0] src, input logic [3:0] dst,
                       input logic isel, input logic [15:0] imm, input bit junk);
    logic [15:0] a, b;
    logic [20:0] m;
    bit legal, wr;
    int n;
    n = 0;
    while (rq.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (rq.req_ready !== 1'b1) $display("FAIL ready_wait: ready=%b required 1", rq.req_ready);
    else passes++;
    a = (IMM_EN && isel) ? imm : mrf[src];
    b = mrf[dst];
    m = alu_model(op, a, b);
    legal = (op <= 5'd9);
    wr = legal && (op != 5'd2);
    rq.req_valid = 1'b1; rq.req_op = op; rq.req_src = src; rq.req_dst = dst;
    rq.req_imm_sel = isel; rq.req_imm = imm;
    @(negedge clk);
    if (junk) begin
      rq.req_op = 5'($urandom); rq.req_src = 4'($urandom); rq.req_dst = 4'($urandom);
      rq.req_imm_sel = 1'($urandom); rq.req_imm = 16'($urandom);
    end else rq.req_valid = 1'b0;
    checks++;
    if (done !== 1'b0 || rq.req_ready !== 1'b0)
      $display("FAIL read_busy: done=%b ready=%b required 0/0", done, rq.req_ready);
    else passes++;
    @(negedge clk);
    checks++;
    if (alu_rsrc !== a || alu_rdest !== b || alu_opcode !== op)
      $display("FAIL exec_drive: rsrc=%h rdest=%h op=%0d required %h %h %0d",
               alu_rsrc, alu_rdest, alu_opcode, a, b, op);
    else passes++;
    checks++;
    if (done !== 1'b0) $display("FAIL exec_done: done=%b required 0", done);
    else passes++;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || err !== !legal || rf_we !== wr)
      $display("FAIL wb_ctrl: done=%b err=%b we=%b required 1 %b %b", done, err, rf_we, !legal, wr);
    else passes++;
    if (wr) begin
      checks++;
      if (rf_waddr !== dst || rf_wdata !== m[15:0])
        $display("FAIL wb_data: waddr=%0d wdata=%h required %0d %h", rf_waddr, rf_wdata, dst, m[15:0]);
      else passes++;
    end
    @(negedge clk);
    rq.req_valid = 1'b0;
    if (wr) mrf[dst] = m[15:0];
    if (legal) mpsr = m[20:16];
    checks++;
    if (rq.req_ready !== 1'b1 || done !== 1'b0 || psr !== mpsr)
      $display("FAIL retire: ready=%b done=%b psr=%h required 1 0 %h", rq.req_ready, done, psr, mpsr);
    else passes++;
    checks++;
    if (rf[dst] !== mrf[dst]) $display("FAIL rf_state: R%0d=%h required %h", dst, rf[dst], mrf[dst]);
    else passes++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rq.req_ready !== 1'b1 || rf_we !== 1'b0 || done !== 1'b0 || err !== 1'b0 || psr !== 5'd0)
      $display("FAIL reset_ctrl: ready=%b we=%b done=%b err=%b psr=%h required 1 0 0 0 0",
               rq.req_ready, rf_we, done, err, psr);
    else passes++;
    checks++;
    if (rf_raddr_a !== 4'd0 || rf_raddr_b !== 4'd0 || rf_waddr !== 4'd0 || rf_wdata !== 16'd0)
      $display("FAIL reset_rf: ra=%0d rb=%0d wa=%0d wd=%h required zeros",
               rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata);
    else passes++;
    checks++;
    if (alu_rsrc !== 16'd0 || alu_rdest !== 16'd0 || alu_opcode !== 5'd0)
      $display("FAIL reset_alu: rsrc=%h rdest=%h op=%0d required zeros", alu_rsrc, alu_rdest, alu_opcode);
    else passes++;
    reset = 1'b0;
    mpsr = 5'd0;
  endtask

  task automatic test_directed;
    load_reg(4'd0, 16'h0000); load_reg(4'd1, 16'h0001); load_reg(4'd2, 16'h0001);
    load_reg(4'd3, 16'hFFFF); load_reg(4'd4, 16'hFFFF); load_reg(4'd5, 16'h0007);
    load_reg(4'd6, 16'h0007); load_reg(4'd7, 16'h0005);
    do_op(5'd0, 4'd1, 4'd2, 1'b0, 16'h0, 1'b0);
    checks++;
    if (rf[2] !== 16'h0002) $display("FAIL add_r2: R2=%h required 0002", rf[2]);
    else passes++;
    do_op(5'd3, 4'd3, 4'd4, 1'b0, 16'h0, 1'b0);
    checks++;
    if (rf[4] !== 16'hFFFF || psr !== 5'h04) $display("FAIL and_ff: R4=%h psr=%h required FFFF 04", rf[4], psr);
    else passes++;
    do_op(5'd2, 4'd5, 4'd6, 1'b0, 16'h0, 1'b0);
    checks++;
    if (psr !== 5'h08 || rf[6] !== 16'h0007) $display("FAIL cmp_eq: psr=%h R6=%h required 08 0007", psr, rf[6]);
    else passes++;
    do_op(5'h1F, 4'd1, 4'd3, 1'b0, 16'h0, 1'b0);
    checks++;
    if (psr !== 5'h08 || rf[3] !== 16'hFFFF) $display("FAIL illegal_keep: psr=%h R3=%h required 08 FFFF", psr, rf[3]);
    else passes++;
    do_op(5'd0, 4'd0, 4'd7, 1'b1, 16'h0010, 1'b0);
    checks++;
    if (rf[7] !== (IMM_EN ? 16'h0015 : 16'h0005))
      $display("FAIL imm_add: R7=%h required %h", rf[7], IMM_EN ? 16'h0015 : 16'h0005);
    else passes++;
    do_op(5'd5, 4'd5, 4'd5, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 16; i++) load_reg(4'(i), 16'($urandom));
    for (int i = 0; i < 40; i++)
      do_op((i % 9 == 8) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9)),
            4'($urandom), 4'($urandom), 1'($urandom), 16'($urandom), 1'b0);
  endtask

  task automatic test_back_to_back;
    do_op(5'd0, 4'd1, 4'd2, 1'b0, 16'h0, 1'b1);
    do_op(5'd1, 4'd2, 4'd2, 1'b0, 16'h0, 1'b1);
    do_op(5'd9, 4'd3, 4'd2, 1'b0, 16'h0, 1'b1);
    do_op(5'd7, 4'd2, 4'd4, 1'b1, 16'h0003, 1'b1);
  endtask

  task automatic test_reset_midop;
    logic [15:0] keep;
    do_op(5'd2, 4'd5, 4'd5, 1'b0, 16'h0, 1'b0);
    keep = rf[9];
    rq.req_valid = 1'b1; rq.req_op = 5'd1; rq.req_src = 4'd8; rq.req_dst = 4'd9;
    rq.req_imm_sel = 1'b0; rq.req_imm = 16'h0;
    @(negedge clk);
    rq.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mpsr = 5'd0;
    checks++;
    if (rq.req_ready !== 1'b1 || psr !== 5'd0 || done !== 1'b0 || rf_we !== 1'b0 || err !== 1'b0)
      $display("FAIL midop_reset: ready=%b psr=%h done=%b we=%b err=%b required 1 0 0 0 0",
               rq.req_ready, psr, done, rf_we, err);
    else passes++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || rf[9] !== keep) $display("FAIL midop_nowb: done=%b R9=%h required 0 %h", done, rf[9], keep);
    else passes++;
    do_op(5'd0, 4'd8, 4'd9, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pre_we = 1'b0; pre_addr = 4'd0; pre_data = 16'd0;
    rq.req_valid = 1'b0; rq.req_op = 5'd0; rq.req_src = 4'd0; rq.req_dst = 4'd0;
    rq.req_imm_sel = 1'b0; rq.req_imm = 16'd0;
    for (int i = 0; i < 16; i++) mrf[i] = 16'd0;
    mpsr = 5'd0;
    test_reset;
    for (int i = 0; i < 16; i++) load_reg(4'(i), 16'd0);
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_midop;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
